simon_playback_sequencer: RTL and testbench

Sequences the Simon pattern memory during PLAYBACK mode. On a start pulse from the Simon control FSM, it reads stored entries 0..count-1 from the pattern memory one at a time. Each entry is shown on the game LEDs for a fixed on-time, followed by a blank gap. When the last gap ends, it pulses done. It owns the memory read port and the LED drive for the whole of playback.

---
 rtl/simon_pkg.sv | 24 ++
 rtl/simon_playback_sequencer_if.sv | 26 ++
 rtl/simon_interval_timer.sv | 39 +++
 rtl/simon_playback_sequencer.sv | 120 ++++++++++++
 tb/tb_simon_playback_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon playback sequencer: FSM encoding, LED
// blanking level and the interval-timer width helper.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SHOW  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Level driven on every LED while nothing is being shown.
    localparam logic LED_OFF = 1'b0;

    // Bits needed to hold the longer of the two intervals.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/simon_playback_sequencer_if.sv
// Bundle between the Simon control FSM / pattern memory (master side) and
// the playback sequencer (slave side).
interface simon_playback_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int PAT_W  = 4
);
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   count;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [PAT_W-1:0]  mem_rdata;
    logic [PAT_W-1:0]  leds;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, count, mem_rdata,
        input  mem_rd, mem_addr, leds, busy, done
    );

    modport slave (
        input  start, abort, count, mem_rdata,
        output mem_rd, mem_addr, leds, busy, done
    );
endinterface

// File: rtl/simon_interval_timer.sv
// Loadable down-counter shared by the SHOW and GAP intervals. A load of N
// makes expired rise on the N-th following cycle.
module simon_interval_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry reflects the current count only: the SHOW->GAP reload is
    // requested in the very cycle that reports expiry, so folding load in
    // here would both hide that expiry and form a combinational loop.
    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays back entries 0..count-1 of the Simon pattern memory on the LEDs,
// each lit for ON_CYCLES then blanked for OFF_CYCLES, and pulses done.
module simon_playback_sequencer
    import simon_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int PAT_W      = 4,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input logic                       clk,
    input logic                       rst,
    simon_playback_sequencer_if.slave bus
);
    localparam int              TW       = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES);
    localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES);
    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_expired;

    simon_interval_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    // Next-state, datapath updates and timer control; abort overrides all.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        pat_d    = pat_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Clamp so idx (one bit wider than the address) can
                    // always reach len without wrapping.
                    len_d   = (bus.count > MAX_LEN) ? MAX_LEN : bus.count;
                    idx_d   = '0;
                    state_d = (len_d == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                pat_d    = bus.mem_rdata;
                tmr_load = 1'b1;
                tmr_val  = ON_LOAD;
                state_d  = SHOW;
            end
            SHOW: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = (idx_d == len_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d  = IDLE;
            idx_d    = idx_q;
            len_d    = len_q;
            pat_d    = pat_q;
            tmr_load = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign bus.mem_rd   = (state_q == FETCH);
    assign bus.mem_addr = idx_q[ADDR_W-1:0];
    assign bus.leds     = (state_q == SHOW) ? pat_q : {PAT_W{LED_OFF}};
    assign bus.busy     = (state_q == FETCH) || (state_q == LATCH) ||
                          (state_q == SHOW)  || (state_q == GAP);
    assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench for the Simon playback sequencer with ON=3, OFF=2.
module tb_simon_playback_sequencer;
    import simon_pkg::*;

    localparam int ADDR_W = 5;
    localparam int PAT_W  = 4;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    logic [PAT_W-1:0] mem [32];

    typedef struct {
        logic             start;
        logic             abort;
        logic [ADDR_W:0]  count;
        logic [PAT_W-1:0] leds;
        logic             rd;
        logic [ADDR_W-1:0] addr;
        logic             busy;
        logic             done;
    } vec_t;

    vec_t vecs [17];

    simon_playback_sequencer_if #(.ADDR_W(ADDR_W), .PAT_W(PAT_W)) bus ();

    simon_playback_sequencer #(
        .ADDR_W    (ADDR_W),
        .PAT_W     (PAT_W),
        .ON_CYCLES (3),
        .OFF_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read pattern memory: data the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input logic st, input logic ab, input logic [ADDR_W:0] cnt,
                           input logic [PAT_W-1:0] l, input logic r, input logic [ADDR_W-1:0] a,
                           input logic b, input logic d);
        vecs[i].start = st; vecs[i].abort = ab; vecs[i].count = cnt;
        vecs[i].leds = l; vecs[i].rd = r; vecs[i].addr = a; vecs[i].busy = b; vecs[i].done = d;
    endtask

    initial begin
        int done_cnt, done_cyc, rd_first, rd_second, rd_addr0, fetch_n, addr_err, cyc;
        logic got;

        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 32; i++) mem[i] = PAT_W'(i);
        mem[0] = 4'b0001;
        mem[1] = 4'b0100;

        // Row i: inputs before edge i, outputs expected in cycle i+1.
        set_vec(0,  1, 0, 6'd2, 4'h0, 1, 5'd0, 1, 0);
        set_vec(1,  1, 0, 6'd5, 4'h0, 0, 5'd0, 1, 0);
        set_vec(2,  0, 0, 6'd7, 4'h1, 0, 5'd0, 1, 0);
        set_vec(3,  0, 0, 6'd7, 4'h1, 0, 5'd0, 1, 0);
        set_vec(4,  0, 0, 6'd7, 4'h1, 0, 5'd0, 1, 0);
        set_vec(5,  1, 0, 6'd7, 4'h0, 0, 5'd0, 1, 0);
        set_vec(6,  0, 0, 6'd7, 4'h0, 0, 5'd0, 1, 0);
        set_vec(7,  0, 0, 6'd0, 4'h0, 1, 5'd1, 1, 0);
        set_vec(8,  0, 0, 6'd0, 4'h0, 0, 5'd1, 1, 0);
        set_vec(9,  0, 0, 6'd0, 4'h4, 0, 5'd1, 1, 0);
        set_vec(10, 0, 0, 6'd0, 4'h4, 0, 5'd1, 1, 0);
        set_vec(11, 0, 0, 6'd0, 4'h4, 0, 5'd1, 1, 0);
        set_vec(12, 0, 0, 6'd0, 4'h0, 0, 5'd1, 1, 0);
        set_vec(13, 0, 0, 6'd0, 4'h0, 0, 5'd1, 1, 0);
        set_vec(14, 0, 0, 6'd2, 4'h0, 0, 5'd2, 0, 1);
        set_vec(15, 1, 0, 6'd2, 4'h0, 0, 5'd2, 0, 0);
        set_vec(16, 0, 0, 6'd2, 4'h0, 0, 5'd2, 0, 0);

        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.count = '0;
        step();
        step();
        check("reset leds", 32'(bus.leds), 32'h0);
        check("reset mem_rd", 32'(bus.mem_rd), 32'h0);
        check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset done", 32'(bus.done), 32'h0);
        #4 rst = 1'b1;

        // Two-entry playback, count changes and start while busy/in DONE.
        for (int i = 0; i < 17; i++) begin
            bus.start = vecs[i].start;
            bus.abort = vecs[i].abort;
            bus.count = vecs[i].count;
            step();
            check($sformatf("row%0d leds", i), 32'(bus.leds), 32'(vecs[i].leds));
            check($sformatf("row%0d mem_rd", i), 32'(bus.mem_rd), 32'(vecs[i].rd));
            check($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
            check($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            check($sformatf("row%0d done", i), 32'(bus.done), 32'(vecs[i].done));
        end

        // count=0: immediate done, no fetch, idx cleared.
        bus.start = 1'b1;
        bus.count = 6'd0;
        step();
        check("zero done", 32'(bus.done), 32'h1);
        check("zero busy", 32'(bus.busy), 32'h0);
        check("zero mem_rd", 32'(bus.mem_rd), 32'h0);
        check("zero mem_addr", 32'(bus.mem_addr), 32'h0);
        bus.start = 1'b0;
        step();
        check("zero done drop", 32'(bus.done), 32'h0);
        check("zero busy after", 32'(bus.busy), 32'h0);

        // Abort in SHOW of entry 0.
        bus.start = 1'b1;
        bus.count = 6'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("abort pre leds", 32'(bus.leds), 32'h1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort leds", 32'(bus.leds), 32'h0);
        check("abort busy", 32'(bus.busy), 32'h0);
        check("abort mem_rd", 32'(bus.mem_rd), 32'h0);
        check("abort state", 32'(dut.state_q), 32'(IDLE));
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'h0);

        // abort and start together in IDLE: stay idle.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.count = 6'd1;
        step();
        check("abort+start state", 32'(dut.state_q), 32'(IDLE));
        check("abort+start mem_rd", 32'(bus.mem_rd), 32'h0);
        bus.abort = 1'b0;

        // start held through a count=1 playback; replay starts at addr 0.
        done_cnt = 0; done_cyc = -1; rd_first = -1; rd_second = -1; rd_addr0 = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.mem_rd) begin
                if (rd_first < 0) begin
                    rd_first = c;
                    rd_addr0 = int'(bus.mem_addr);
                end else if (rd_second < 0) begin
                    rd_second = c;
                end
            end
        end
        check("held done count", 32'(done_cnt), 32'd1);
        check("held done cycle", 32'(done_cyc), 32'd8);
        check("held first fetch", 32'(rd_first), 32'd1);
        check("held first addr", 32'(rd_addr0), 32'd0);
        check("held second fetch", 32'(rd_second), 32'd10);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();

        // count=63 clamps to 32 entries, addresses 0..31 in order.
        bus.start = 1'b1;
        bus.count = 6'd63;
        step();
        bus.start = 1'b0;
        fetch_n = 0; addr_err = 0; cyc = 1; got = 1'b0;
        while (cyc <= 400) begin
            if (bus.mem_rd) begin
                if (int'(bus.mem_addr) != fetch_n) addr_err++;
                fetch_n++;
            end
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            step();
            cyc++;
        end
        check("clamp done seen", 32'(got), 32'h1);
        check("clamp done cycle", 32'(cyc), 32'd225);
        check("clamp fetches", 32'(fetch_n), 32'd32);
        check("clamp addr order", 32'(addr_err), 32'd0);
        step();

        // Asynchronous reset in the GAP of entry 1.
        bus.start = 1'b1;
        bus.count = 6'd2;
        step();
        bus.start = 1'b0;
        for (int c = 2; c <= 13; c++) step();
        check("gap pre busy", 32'(bus.busy), 32'h1);
        check("gap pre addr", 32'(bus.mem_addr), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async busy", 32'(bus.busy), 32'h0);
        check("async mem_addr", 32'(bus.mem_addr), 32'h0);
        check("async leds", 32'(bus.leds), 32'h0);
        check("async mem_rd", 32'(bus.mem_rd), 32'h0);
        check("async done", 32'(bus.done), 32'h0);
        step();
        #3 rst = 1'b1;
        step();
        check("post reset state", 32'(dut.state_q), 32'(IDLE));
        check("post reset busy", 32'(bus.busy), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
